// File: rtl/pattern_count_engine.sv
// Streaming pattern-count engine. It counts matches of a PAT_W-bit pattern in a LEN-element message.
// The counts are in-byte matches, bytes holding a match, and matches anywhere in the concatenated stream.
module pattern_count_engine #(
  parameter int BYTE_W = 8,
  parameter int PAT_W  = 4,
  parameter int LEN    = 32,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [PAT_W-1:0]  pat,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ctb,
  output logic [CNT_W-1:0]  cto,
  output logic [CNT_W-1:0]  cts
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // The carry is kept at least one bit wide so that PAT_W=1 still elaborates.
  // With PAT_W=1 the carry is never compared.
  localparam int CW   = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam int BC_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [BC_W-1:0]  LAST = BC_W'(LEN - 1);
  localparam logic [CNT_W:0]   ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   MAX  = {1'b0, {CNT_W{1'b1}}};

  state_t              state, state_nx;
  logic [PAT_W-1:0]    pat_q;
  logic [CW-1:0]       carry;
  logic [BC_W-1:0]     byte_cnt;
  logic                xfer;
  logic [CNT_W:0]      m, b;
  logic [CW+BYTE_W-1:0] cat;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [CNT_W:0]   inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, acc} + inc;
    return (sum >= MAX) ? MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  endfunction

  assign xfer = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && byte_cnt == LAST) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Match counting for the in-byte windows and for the windows that straddle the previous byte.
  always_comb begin
    m   = '0;
    b   = '0;
    cat = {carry, in_data};
    for (int k = 0; k <= BYTE_W - PAT_W; k++)
      if (in_data[k +: PAT_W] == pat_q) m = m + ONE;
    for (int j = 0; j < PAT_W - 1; j++)
      if (cat[BYTE_W - PAT_W + 1 + j +: PAT_W] == pat_q) b = b + ONE;
    if (byte_cnt == '0) b = '0;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pat_q    <= '0;
      carry    <= '0;
      byte_cnt <= '0;
      ctb      <= '0;
      cto      <= '0;
      cts      <= '0;
    end else if (state == IDLE && start) begin
      pat_q    <= pat;
      carry    <= '0;
      byte_cnt <= '0;
      ctb      <= '0;
      cto      <= '0;
      cts      <= '0;
    end else if (xfer) begin
      carry    <= in_data[CW-1:0];
      byte_cnt <= byte_cnt + BC_W'(1);
      ctb      <= sat_add(ctb, m);
      cto      <= sat_add(cto, (m != '0) ? ONE : '0);
      cts      <= sat_add(cts, m + b);
    end
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Directed bench for pattern_count_engine using default parameters plus a CNT_W=7 copy.
// The CNT_W=7 copy shares the same stimulus and is used to check saturation.
module tb_pattern_count_engine;

  logic       CLK = 1'b0;
  logic       reset, start, in_valid;
  logic [3:0] pat;
  logic [7:0] in_data;
  logic       in_ready, busy, done;
  logic [7:0] ctb, cto, cts;
  logic       in_ready7, busy7, done7;
  logic [6:0] ctb7, cto7, cts7;

  int tests = 0;
  int fails = 0;
  logic [7:0] msg [32];

  pattern_count_engine dut (
    .CLK(CLK), .reset(reset), .start(start), .pat(pat), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .busy(busy), .done(done),
    .ctb(ctb), .cto(cto), .cts(cts)
  );

  pattern_count_engine #(.CNT_W(7)) dut7 (
    .CLK(CLK), .reset(reset), .start(start), .pat(pat), .in_valid(in_valid),
    .in_ready(in_ready7), .in_data(in_data), .busy(busy7), .done(done7),
    .ctb(ctb7), .cto(cto7), .cts(cts7)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_results(input string tag, input int e_ctb, input int e_cto, input int e_cts);
    check({tag, "_ctb"}, ctb, e_ctb);
    check({tag, "_cto"}, cto, e_cto);
    check({tag, "_cts"}, cts, e_cts);
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    int w;
    in_valid = 1'b0;
    in_data  = 8'hA5;
    repeat (gap) step();
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_msg(input logic [3:0] p, input bit gaps, input bit mid_start, input string tag);
    int early;
    start = 1'b1;
    pat   = p;
    step();
    start = 1'b0;
    pat   = ~p;
    check({tag, "_busy_run"}, busy, 1);
    check({tag, "_ready_run"}, in_ready, 1);
    early = 0;
    for (int i = 0; i < 32; i++) begin
      if (mid_start && i == 10) begin
        start = 1'b1;
        pat   = 4'hF;
      end
      send(msg[i], gaps ? int'($urandom_range(0, 2)) : 0);
      start = 1'b0;
      if (i < 31 && done) early++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_fin"}, busy, 0);
    check({tag, "_ready_fin"}, in_ready, 0);
    check({tag, "_early_done"}, early, 0);
    // A start raised during the FIN cycle must be dropped.
    start = 1'b1;
    pat   = 4'hF;
    step();
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    pat      = 4'h0;
    repeat (2) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_results("rst", 0, 0, 0);
    reset = 1'b0;
    step();

    // Case 1: 0101 in 0x55 gives 3 per byte plus 1 per boundary.
    for (int i = 0; i < 32; i++) msg[i] = 8'h55;
    run_msg(4'b0101, 1'b0, 1'b0, "c1");
    check_results("c1", 96, 32, 127);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (2) step();
    in_valid = 1'b0;
    check_results("c1_hold", 96, 32, 127);

    // Case 2 and case 4: all-zero data, plus the saturating 7-bit copy.
    for (int i = 0; i < 32; i++) msg[i] = 8'h00;
    run_msg(4'b0000, 1'b0, 1'b0, "c2");
    check_results("c2", 160, 32, 253);
    check("c4_ctb7", ctb7, 127);
    check("c4_cto7", cto7, 32);
    check("c4_cts7", cts7, 127);
    run_msg(4'b1111, 1'b0, 1'b0, "c2f");
    check_results("c2f", 0, 0, 0);
    check("c2f_cts7", cts7, 0);

    // Case 3: 1001 matches only across each 0x01 -> 0x20 boundary.
    for (int i = 0; i < 32; i++) msg[i] = (i % 2 == 0) ? 8'h01 : 8'h20;
    run_msg(4'b1001, 1'b0, 1'b0, "c3");
    check_results("c3", 0, 0, 16);

    // Case 5: case 1 with valid gaps and an ignored mid-run start.
    for (int i = 0; i < 32; i++) msg[i] = 8'h55;
    run_msg(4'b0101, 1'b1, 1'b1, "c5");
    check_results("c5", 96, 32, 127);

    // Case 6: async reset mid-run, then a clean rerun.
    start = 1'b1;
    pat   = 4'b0101;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) send(8'h55, 0);
    #2;
    reset = 1'b1;
    #1;
    check("c6_rst_busy", busy, 0);
    check("c6_rst_ready", in_ready, 0);
    check("c6_rst_done", done, 0);
    check_results("c6_rst", 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    run_msg(4'b0101, 1'b0, 1'b0, "c6");
    check_results("c6", 96, 32, 127);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
